// File: rtl/turbo_pkg.sv
// Shared turbo-decoder constants: default widths, block geometry, saturation limits
// and the extrinsic interleaver FSM state encoding.
package turbo_pkg;

    localparam int DATA_SIZE  = 10;
    localparam int IN_SIZE    = 5;
    localparam int BLOCK_SIZE = 3 * (IN_SIZE + 2);
    localparam int PI_STEP    = 5;

    localparam int SAT_MAX = (1 << (IN_SIZE - 1)) - 1;
    localparam int SAT_MIN = -(1 << (IN_SIZE - 1));

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/pi_addr_gen.sv
// Interleave address generator: walks pi(j) = (PI_STEP*j) mod BLOCK_SIZE one step
// per advance using a single add and conditional subtract.
module pi_addr_gen #(
    parameter int BLOCK_SIZE = turbo_pkg::BLOCK_SIZE,
    parameter int PI_STEP    = turbo_pkg::PI_STEP,
    parameter int ADDR_W     = $clog2(turbo_pkg::BLOCK_SIZE)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   w_sum;
    logic [ADDR_W:0]   w_wrapped;
    logic [ADDR_W-1:0] w_next;

    // PI_STEP < BLOCK_SIZE, so one conditional subtract always lands back in range.
    assign w_sum     = {1'b0, r_addr} + (ADDR_W + 1)'(PI_STEP);
    assign w_wrapped = (w_sum >= (ADDR_W + 1)'(BLOCK_SIZE)) ? w_sum - (ADDR_W + 1)'(BLOCK_SIZE) : w_sum;
    assign w_next    = w_wrapped[ADDR_W-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr <= '0;
        end else if (clear_i) begin
            r_addr <= '0;
        end else if (advance_i) begin
            r_addr <= w_next;
        end
    end

    assign addr_o = r_addr;

endmodule

// File: rtl/ext_interleaver.sv
// Extrinsic interleaver: scales/saturates (llr - sys - ext) into a block buffer in
// natural order, then streams it out in pi-interleaved order with ready/valid flow control.
module ext_interleaver #(
    parameter int DATA_SIZE  = turbo_pkg::DATA_SIZE,
    parameter int IN_SIZE    = turbo_pkg::IN_SIZE,
    parameter int BLOCK_SIZE = turbo_pkg::BLOCK_SIZE,
    parameter int PI_STEP    = turbo_pkg::PI_STEP
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        llr_valid_i,
    output logic                        llr_ready_o,
    input  logic signed [DATA_SIZE-1:0] llr_i,
    input  logic signed [IN_SIZE-1:0]   sys_i,
    input  logic signed [IN_SIZE-1:0]   ext_i,
    output logic                        ext_valid_o,
    input  logic                        ext_ready_i,
    output logic signed [IN_SIZE-1:0]   ext_o,
    output logic                        ext_last_o,
    output logic                        busy_o
);

    import turbo_pkg::*;

    localparam int ADDR_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int EW     = DATA_SIZE + 2;

    localparam logic [ADDR_W-1:0]    LAST_IDX   = ADDR_W'(BLOCK_SIZE - 1);
    localparam logic [ADDR_W-1:0]    PENULT_IDX = ADDR_W'(BLOCK_SIZE - 2);
    localparam logic signed [EW-1:0] SAT_HI     = EW'((1 << (IN_SIZE - 1)) - 1);
    localparam logic signed [EW-1:0] SAT_LO     = ~SAT_HI;

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_W-1:0] r_wr_cnt;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic [ADDR_W-1:0] w_addr;

    logic signed [IN_SIZE-1:0] r_mem [0:BLOCK_SIZE-1];
    logic signed [IN_SIZE-1:0] r_ext;
    logic                      r_ext_valid;
    logic                      r_ext_last;

    logic signed [EW-1:0]      w_llr_x;
    logic signed [EW-1:0]      w_sys_x;
    logic signed [EW-1:0]      w_ext_x;
    logic signed [EW-1:0]      w_e;
    logic signed [EW-1:0]      w_es;
    logic signed [IN_SIZE-1:0] w_sat;

    logic w_fill;
    logic w_wr;
    logic w_wr_last;
    logic w_hs;
    logic w_hs_last;
    logic w_load;

    // Extrinsic = a-posteriori minus systematic minus a-priori, scaled by 0.75 (floor).
    assign w_llr_x = {{(EW - DATA_SIZE){llr_i[DATA_SIZE-1]}}, llr_i};
    assign w_sys_x = {{(EW - IN_SIZE){sys_i[IN_SIZE-1]}}, sys_i};
    assign w_ext_x = {{(EW - IN_SIZE){ext_i[IN_SIZE-1]}}, ext_i};
    assign w_e     = w_llr_x - w_sys_x - w_ext_x;
    assign w_es    = w_e - (w_e >>> 2);
    assign w_sat   = (w_es > SAT_HI) ? SAT_HI[IN_SIZE-1:0] :
                     (w_es < SAT_LO) ? SAT_LO[IN_SIZE-1:0] : w_es[IN_SIZE-1:0];

    assign w_fill    = (r_state == ST_FILL);
    assign w_wr      = llr_valid_i & w_fill;
    assign w_wr_last = w_wr & (r_wr_cnt == LAST_IDX);
    assign w_hs      = r_ext_valid & ext_ready_i;
    assign w_hs_last = w_hs & (r_rd_cnt == LAST_IDX);
    // The output register loads element 0 on the closing write, then one element per handshake.
    assign w_load    = w_wr_last | (w_hs & ~w_hs_last);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        llr_ready_o = 1'b0;
        busy_o      = 1'b0;
        case (r_state)
            ST_FILL: begin
                llr_ready_o = 1'b1;
                if (w_wr_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy_o = 1'b1;
                if (w_hs_last) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_cnt <= '0;
        end else if (w_wr) begin
            r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_cnt <= '0;
        end else if (w_wr_last || w_hs_last) begin
            r_rd_cnt <= '0;
        end else if (w_hs) begin
            r_rd_cnt <= r_rd_cnt + 1'b1;
        end
    end

    // NOTE: the buffer has no reset; a reset discards the block through the counters instead.
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wr_cnt] <= w_sat;
        end
    end

    pi_addr_gen #(
        .BLOCK_SIZE(BLOCK_SIZE),
        .PI_STEP   (PI_STEP),
        .ADDR_W    (ADDR_W)
    ) u_pi_addr_gen (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (w_hs_last),
        .advance_i(w_load),
        .addr_o   (w_addr)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ext       <= '0;
            r_ext_valid <= 1'b0;
            r_ext_last  <= 1'b0;
        end else if (w_hs_last) begin
            r_ext_valid <= 1'b0;
            r_ext_last  <= 1'b0;
        end else if (w_load) begin
            r_ext       <= r_mem[w_addr];
            r_ext_valid <= 1'b1;
            r_ext_last  <= w_wr_last ? (BLOCK_SIZE == 1) : (r_rd_cnt == PENULT_IDX);
        end
    end

    assign ext_o       = r_ext;
    assign ext_valid_o = r_ext_valid;
    assign ext_last_o  = r_ext_last;

endmodule

// File: tb/tb_ext_interleaver.sv
// Directed bench for ext_interleaver: scaling table, interleave order, backpressure,
// back-to-back blocks, input gaps, writes ignored while draining, and resets mid-block.
module tb_ext_interleaver;

    localparam int DW = 10;
    localparam int IW = 5;
    localparam int BS = 21;

    typedef struct {
        int llr;
        int sys;
        int ext;
        int exp;
    } vec_t;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 llr_valid_i;
    logic                 llr_ready_o;
    logic signed [DW-1:0] llr_i;
    logic signed [IW-1:0] sys_i;
    logic signed [IW-1:0] ext_i;
    logic                 ext_valid_o;
    logic                 ext_ready_i;
    logic signed [IW-1:0] ext_o;
    logic                 ext_last_o;
    logic                 busy_o;

    int n_chk = 0;
    int n_err = 0;

    int blk_llr [BS];
    int blk_sys [BS];
    int blk_ext [BS];
    int blk_exp [BS];
    int perm    [BS] = '{0, 5, 10, 15, 20, 4, 9, 14, 19, 3, 8, 13, 18, 2, 7, 12, 17, 1, 6, 11, 16};
    vec_t scale_tab [BS];

    ext_interleaver dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .llr_valid_i(llr_valid_i),
        .llr_ready_o(llr_ready_o),
        .llr_i      (llr_i),
        .sys_i      (sys_i),
        .ext_i      (ext_i),
        .ext_valid_o(ext_valid_o),
        .ext_ready_i(ext_ready_i),
        .ext_o      (ext_o),
        .ext_last_o (ext_last_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Value e with e - floor(e/4) == v, so a block can store exactly the values we pick.
    function automatic int inv_scale(input int v);
        int q;
        q = (v >= 0) ? v / 3 : -((-v + 2) / 3);
        return 4 * q + (v - 3 * q);
    endfunction

    task automatic load_table();
        scale_tab = '{
            '{10, 2, 1, 6},      '{-7, 0, 0, -5},     '{40, 5, 3, 15},    '{-40, 5, 3, -16},
            '{0, 0, 0, 0},       '{3, 0, 0, 3},       '{-1, 0, 0, 0},     '{-4, 0, 0, -3},
            '{19, 0, 0, 15},     '{21, 0, 0, 15},     '{-20, 0, 0, -15},  '{-22, 0, 0, -16},
            '{511, -16, -16, 15}, '{-512, 15, 15, -16}, '{5, 1, -1, 4},   '{-13, -3, -2, -6},
            '{100, -16, 15, 15}, '{2, 0, 0, 2},       '{-2, 0, 0, -1},    '{8, 0, 0, 6},
            '{-9, 1, 1, -8}
        };
        for (int k = 0; k < BS; k++) begin
            blk_llr[k] = scale_tab[k].llr;
            blk_sys[k] = scale_tab[k].sys;
            blk_ext[k] = scale_tab[k].ext;
            blk_exp[k] = scale_tab[k].exp;
        end
    endtask

    // Stored value of symbol k is dir*(k-10); sys/ext vary so the subtraction is exercised.
    task automatic load_ramp(input int dir);
        for (int k = 0; k < BS; k++) begin
            blk_exp[k] = dir * (k - 10);
            blk_sys[k] = (k % 5) - 2;
            blk_ext[k] = (k % 3) - 1;
            blk_llr[k] = inv_scale(blk_exp[k]) + blk_sys[k] + blk_ext[k];
        end
    endtask

    task automatic send_block(input int n, input int gap, input bit hold_after);
        for (int k = 0; k < n; k++) begin
            if (gap > 0 && k > 0 && (k % gap) == 0) begin
                llr_valid_i = 1'b0;
                llr_i = -10'sd300;
                sys_i = 5'sd7;
                ext_i = -5'sd8;
                @(posedge clk_i); #1;
            end
            check("fill_ready", int'(llr_ready_o), 1);
            check("fill_no_valid", int'(ext_valid_o), 0);
            llr_valid_i = 1'b1;
            llr_i = DW'(blk_llr[k]);
            sys_i = IW'(blk_sys[k]);
            ext_i = IW'(blk_ext[k]);
            @(posedge clk_i); #1;
        end
        if (hold_after) begin
            llr_valid_i = 1'b1;
            llr_i = 10'sd255;
            sys_i = -5'sd16;
            ext_i = -5'sd16;
        end else begin
            llr_valid_i = 1'b0;
        end
    endtask

    task automatic drain(input int stall_at, input int stall_len, input int stop_at);
        int j = 0;
        int stalls = 0;
        int cyc = 0;
        check("first_valid_latency", int'(ext_valid_o), 1);
        while (j < stop_at && cyc < 200) begin
            check("valid_no_bubble", int'(ext_valid_o), 1);
            check("drain_llr_ready", int'(llr_ready_o), 0);
            check("drain_busy", int'(busy_o), 1);
            check("ext_o", int'(ext_o), blk_exp[perm[j]]);
            check("ext_last", int'(ext_last_o), int'(j == BS - 1));
            if (j == stall_at && stalls < stall_len) begin
                ext_ready_i = 1'b0;
                stalls++;
            end else begin
                ext_ready_i = 1'b1;
                j++;
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        ext_ready_i = 1'b1;
        llr_valid_i = 1'b0;
        if (j < stop_at) begin
            check("drain_timeout", j, stop_at);
        end
        if (stop_at == BS) begin
            check("end_valid_low", int'(ext_valid_o), 0);
            check("end_last_low", int'(ext_last_o), 0);
            check("end_llr_ready", int'(llr_ready_o), 1);
            check("end_busy_low", int'(busy_o), 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ext_valid"}, int'(ext_valid_o), 0);
        check({tag, "_ext_last"}, int'(ext_last_o), 0);
        check({tag, "_ext_o"}, int'(ext_o), 0);
        check({tag, "_busy"}, int'(busy_o), 0);
        check({tag, "_llr_ready"}, int'(llr_ready_o), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i       = 1'b1;
        llr_valid_i = 1'b0;
        llr_i       = '0;
        sys_i       = '0;
        ext_i       = '0;
        ext_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        check("ready_after_reset", int'(llr_ready_o), 1);

        // Scaling and saturation through a full block.
        load_table();
        send_block(BS, 0, 1'b0);
        drain(-1, 0, BS);

        // Interleave order, then a back-to-back block with a 3-cycle stall at j=4.
        load_ramp(1);
        send_block(BS, 0, 1'b0);
        drain(-1, 0, BS);
        load_ramp(-1);
        send_block(BS, 0, 1'b0);
        drain(4, 3, BS);

        // Input gaps during fill, llr_valid_i held high throughout drain.
        load_ramp(1);
        send_block(BS, 3, 1'b1);
        drain(-1, 0, BS);

        // Reset mid-fill: the partial block is discarded.
        load_table();
        send_block(10, 0, 1'b0);
        #2 rst_i = 1'b1;
        #1 check_reset_outputs("rst_fill");
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        load_ramp(-1);
        send_block(BS, 0, 1'b0);
        drain(-1, 0, BS);

        // Reset at j=7 of drain, then a fresh block with gaps and a stall.
        load_ramp(1);
        send_block(BS, 0, 1'b0);
        drain(-1, 0, 7);
        #2 rst_i = 1'b1;
        #1 check_reset_outputs("rst_drain");
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        load_table();
        send_block(BS, 2, 1'b0);
        drain(2, 2, BS);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ext_interleaver.md
EXT_INTERLEAVER -- requirements
Module: ext_interleaver

Interface
REQ-001 Parameter DATA_SIZE, default 10: width of the signed LLR input.
REQ-002 Parameter IN_SIZE, default 5: width of the signed sys/ext/extrinsic samples.
REQ-003 Parameter BLOCK_SIZE, default 21: symbols per block (3 * (IN_SIZE+2)).
REQ-004 Parameter PI_STEP, default 5: interleaver step; it SHALL be coprime with BLOCK_SIZE.
REQ-005 clk_i  input  1  single clock; all state updates on rising edge.
REQ-006 rst_i  input  1  reset, asynchronous and active-high.
REQ-007 llr_valid_i  input  1  llr_i, sys_i and ext_i valid for the current symbol.
REQ-008 llr_ready_o  output  1  block accepts a symbol this cycle.
REQ-009 llr_i  input  DATA_SIZE  signed a-posteriori LLR from the SISO, in natural order.
REQ-010 sys_i  input  IN_SIZE  signed systematic sample aligned with llr_i.
REQ-011 ext_i  input  IN_SIZE  signed a-priori (incoming extrinsic) sample aligned with llr_i.
REQ-012 ext_valid_o  output  1  ext_o holds a valid interleaved extrinsic.
REQ-013 ext_ready_i  input  1  downstream SISO loader accepts ext_o.
REQ-014 ext_o  output  IN_SIZE  signed scaled, saturated extrinsic in interleaved order.
REQ-015 ext_last_o  output  1  high with the final (BLOCK_SIZE-th) output of a block.
REQ-016 busy_o  output  1  high while in DRAIN.

Function
REQ-017 The FSM SHALL have two states: FILL and DRAIN.
REQ-018 In FILL, llr_ready_o SHALL be 1; in DRAIN, it SHALL be 0.
REQ-019 A write SHALL occur on each cycle with llr_valid_i & llr_ready_o, storing to mem[wr_cnt] and incrementing wr_cnt.
REQ-020 The stored value SHALL be computed in DATA_SIZE+2 bits as e = llr_i - sys_i - ext_i, with sign extension.
REQ-021 Scaling SHALL be e_s = e - (e >>> 2): arithmetic shift, floor, giving 0.75 scaling.
REQ-022 e_s SHALL saturate to IN_SIZE signed, i.e. [-16, 15] for the defaults.
REQ-023 On the write with wr_cnt = BLOCK_SIZE-1, the FSM SHALL go to DRAIN, clear wr_cnt and set rd_cnt = 0 and addr = 0.
REQ-024 The first ext_valid_o SHALL be asserted on the cycle after that write (latency 1), with ext_o = mem[0].
REQ-025 The output sequence SHALL be mem[pi(j)] for j = 0..BLOCK_SIZE-1, where pi(j) = (PI_STEP*j) mod BLOCK_SIZE.
REQ-026 pi(j) SHALL be generated incrementally: addr += PI_STEP, then subtract BLOCK_SIZE if addr >= BLOCK_SIZE; no multiplier or divider.
REQ-027 ext_o, ext_valid_o and ext_last_o SHALL be registered.
REQ-028 ext_o, ext_valid_o and ext_last_o SHALL hold stable while ext_valid_o & !ext_ready_i (backpressure stall).
REQ-029 The output SHALL advance one element per cycle while ext_ready_i = 1, with no bubbles.
REQ-030 ext_last_o SHALL be 1 only with j = BLOCK_SIZE-1.
REQ-031 On the handshake of the last element, the FSM SHALL go to FILL, and ext_valid_o SHALL go to 0 the next cycle.
REQ-032 The first write of the next block SHALL be possible on the cycle after the last handshake.
REQ-033 llr_valid_i asserted during DRAIN SHALL be ignored; no write occurs.
REQ-034 Gaps in llr_valid_i during FILL SHALL stall wr_cnt without data loss.

Reset
REQ-035 On rst_i = 1, the block SHALL immediately enter FILL, clear wr_cnt, rd_cnt and addr, and drive ext_valid_o = 0, ext_last_o = 0, ext_o = 0 and busy_o = 0.
REQ-036 On reset, llr_ready_o SHALL be 1 after reset release.
REQ-037 Memory contents SHALL NOT be reset.
REQ-038 Reset mid-FILL or mid-DRAIN SHALL discard the partial block; the next accepted symbol is index 0.

Structure
REQ-039 A shared package turbo_pkg SHALL hold DATA_SIZE, IN_SIZE, BLOCK_SIZE, PI_STEP, the saturation limits and the FILL/DRAIN state encoding.
REQ-040 The interleave address recurrence SHALL live in one sub-module, pi_addr_gen, with inputs clear and advance and output addr.

Verification
REQ-041 Scaling/saturation: (llr, sys, ext) = (10,2,1) -> 6; (-7,0,0) -> -5; (40,5,3) -> 15; (-40,5,3) -> -16.
REQ-042 Order: write mem[k] = k-10 for k = 0..20, with ext_ready_i = 1 -> output indices 0,5,10,15,20,4,9,14,19,3,8,13,18,2,7,12,17,1,6,11,16; ext_last_o on the 21st output only.
REQ-043 Backpressure: drop ext_ready_i for 3 cycles at j = 4 -> ext_o holds mem[20] for 4 cycles; total sequence unchanged.
REQ-044 Back-to-back blocks: two blocks streamed -> llr_ready_o = 1 on the cycle after the first block's last handshake; no output lost or duplicated.
REQ-045 Reset at j = 7 of DRAIN -> ext_valid_o = 0 immediately; llr_ready_o = 1; a fresh block is output in full, correct order.
REQ-046 llr_valid_i held at 1 during DRAIN -> no memory change; drain output matches the first block's data.
